// File: rtl/cordic_engine.sv
// cordic_engine: iterative sine/cosine engine.
//
// An angle in signed Q.F radians is folded into [-pi/2, pi/2]. The engine then
// spends STAGES cycles in RUN. Each cycle applies N chained cordic_stage
// micro-rotations, so it performs I = STAGES*N iterations in total. At the end
// it registers cos/sin and pulses done for one cycle.
//
// cordic_stage ports:
//   x, y, z   in   current vector and residual angle
//   atan      in   atan(2^-idx) in Q.F
//   idx       in   iteration index, used as the shift amount
//   x_next, y_next, z_next  out  rotated vector and updated residual
//
// cordic_engine ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only while idle
//   angle    in   signed Q.F radians, |angle| <= pi
//   busy     out  high while iterating
//   done     out  one-cycle pulse when cos_out/sin_out update
//   cos_out  out  signed Q.F cosine
//   sin_out  out  signed Q.F sine

module cordic_stage #(
    parameter int W  = 40,
    parameter int IW = 5
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [W-1:0]  z,
    input  logic signed [W-1:0]  atan,
    input  logic        [IW-1:0] idx,
    output logic signed [W-1:0]  x_next,
    output logic signed [W-1:0]  y_next,
    output logic signed [W-1:0]  z_next
);
    logic signed [W-1:0] x_sh, y_sh;

    always_comb begin
        x_sh = x >>> idx;
        y_sh = y >>> idx;
        // A negative residual means we overshot, so rotate clockwise.
        if (z[W-1]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan;
        end
    end
endmodule

module cordic_engine #(
    parameter int Q      = 4,
    parameter int F      = 36,
    parameter int STAGES = 5,
    parameter int N      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [Q+F-1:0] angle,
    output logic                  busy,
    output logic                  done,
    output logic signed [Q+F-1:0] cos_out,
    output logic signed [Q+F-1:0] sin_out
);
    localparam int W  = Q + F;
    localparam int I  = STAGES * N;
    localparam int IW = $clog2(I);
    localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1;

    // The constants are derived at elaboration time in Q60. pi is taken from
    // its hex expansion; the atan values and the gain use integer arithmetic
    // only.
    localparam logic signed [63:0] PI_Q60 = 64'sh3243F6A8885A308D;

    function automatic logic signed [W-1:0] round_q(input logic signed [63:0] v);
        return W'((v + (64'sd1 <<< (59 - F))) >>> (60 - F));
    endfunction

    // atan(2^-i) from its Taylor series. For i >= 1 the series converges
    // quickly. i == 0 is the exact value pi/4.
    function automatic logic signed [63:0] atan_q60(input int i);
        logic signed [63:0] sum, term, den;
        int e;
        if (i == 0) return PI_Q60 >>> 2;
        sum = '0;
        for (int k = 0; k < 32; k++) begin
            e = i * (2 * k + 1);
            if (e <= 60) begin
                den  = 64'(2 * k + 1);
                term = (64'sd1 <<< (60 - e)) / den;
                sum  = (k % 2 == 0) ? sum + term : sum - term;
            end
        end
        return sum;
    endfunction

    // The inverse CORDIC gain is 1/sqrt(prod(1 + 2^-2i)). The product is
    // formed exactly as shift-and-add. The square root is taken bit by bit.
    function automatic logic signed [63:0] kinv_q60();
        logic [127:0] p2, rem, root, trial;
        p2 = 128'(1) << 60;
        for (int i = 0; i < I; i++) p2 = p2 + (p2 >> (2 * i));
        rem  = p2 << 60;
        root = '0;
        for (int b = 63; b >= 0; b--) begin
            trial = root | (128'(1) << b);
            if (trial * trial <= rem) root = trial;
        end
        return 64'((128'(1) << 120) / root);
    endfunction

    localparam logic signed [W-1:0] HALF_PI = round_q(PI_Q60 >>> 1);
    localparam logic signed [W-1:0] PI_W    = round_q(PI_Q60);
    localparam logic signed [W-1:0] KINV    = round_q(kinv_q60());

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state, state_next;
    logic   [CW-1:0]     cnt;
    logic                neg_r;
    logic signed [W-1:0] x_r, y_r, z_r;
    logic signed [W-1:0] x_last, y_last, z_last;
    logic                last;

    // The ROM is padded to a power of two so that any index value reads a
    // defined entry.
    logic signed [W-1:0] atan_rom [2**IW];
    for (genvar g = 0; g < 2**IW; g++) begin : g_rom
        if (g < I) begin : g_used
            localparam logic signed [W-1:0] ENTRY = round_q(atan_q60(g));
            assign atan_rom[g] = ENTRY;
        end else begin : g_pad
            assign atan_rom[g] = '0;
        end
    end

    // N micro-rotations chained combinationally. This chain is the
    // critical path.
    for (genvar j = 0; j < N; j++) begin : g_stage
        logic signed [W-1:0] xi, yi, zi, xo, yo, zo;
        logic        [IW-1:0] idx;
        if (j == 0) begin : g_first
            assign xi = x_r;
            assign yi = y_r;
            assign zi = z_r;
        end else begin : g_link
            assign xi = g_stage[j-1].xo;
            assign yi = g_stage[j-1].yo;
            assign zi = g_stage[j-1].zo;
        end
        assign idx = IW'(cnt) * IW'(N) + IW'(j);
        cordic_stage #(.W(W), .IW(IW)) u_stage (
            .x      (xi),
            .y      (yi),
            .z      (zi),
            .atan   (atan_rom[idx]),
            .idx    (idx),
            .x_next (xo),
            .y_next (yo),
            .z_next (zo)
        );
    end

    assign x_last = g_stage[N-1].xo;
    assign y_last = g_stage[N-1].yo;
    assign z_last = g_stage[N-1].zo;
    assign last   = (cnt == CW'(STAGES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        // NOTE: state is updated with <= so that every flop samples pre-edge values.
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assigning a default first keeps this block free of latches.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode. busy is a direct decode of the state flop.
    always_comb begin
        busy = (state == RUN);
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every datapath flop is reset here; there are no memory arrays in this block.
            cnt     <= '0;
            neg_r   <= 1'b0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            done    <= 1'b0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Fold into [-pi/2, pi/2]. Shifting the angle by pi
                        // negates both cos and sin, which is undone at the end.
                        if (angle > HALF_PI) begin
                            z_r   <= angle - PI_W;
                            neg_r <= 1'b1;
                        end else if (angle < -HALF_PI) begin
                            z_r   <= angle + PI_W;
                            neg_r <= 1'b1;
                        end else begin
                            z_r   <= angle;
                            neg_r <= 1'b0;
                        end
                        x_r <= KINV;
                        y_r <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    x_r <= x_last;
                    y_r <= y_last;
                    z_r <= z_last;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        cos_out <= neg_r ? -x_last : x_last;
                        sin_out <= neg_r ? -y_last : y_last;
                        done    <= 1'b1;
                        cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine.
// Stimulus tasks push the expected cos/sin and the expected done cycle into a
// queue. A negedge monitor pops an entry and compares it whenever done is
// seen. The expected values come from real-valued $cos/$sin.

module tb_cordic_engine;
    localparam int  Q = 4, F = 36, STAGES = 5, N = 4;
    localparam int  W = Q + F;
    localparam real PI_R = 3.14159265358979323846;
    localparam longint TOL = 64'sd1 <<< (F - 17);

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic signed [W-1:0] angle = '0;
    logic                busy, done;
    logic signed [W-1:0] cos_out, sin_out;

    cordic_engine #(.Q(Q), .F(F), .STAGES(STAGES), .N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .angle   (angle),
        .busy    (busy),
        .done    (done),
        .cos_out (cos_out),
        .sin_out (sin_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint c;
        longint s;
        longint due;
    } exp_t;

    exp_t   sb[$];
    exp_t   last_exp;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    logic   prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint to_q(input real v);
        return longint'($floor(v * (2.0 ** F) + 0.5));
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            check(!prev_done, "done_width", longint'(prev_done), 0);
            check(!busy, "busy_done_overlap", longint'(busy), 0);
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check(absl(longint'(cos_out) - e.c) <= TOL, "cos_out", longint'(cos_out), e.c);
                check(absl(longint'(sin_out) - e.s) <= TOL, "sin_out", longint'(sin_out), e.s);
                check(cyc == e.due, "done_latency", cyc, e.due);
                last_exp = e;
            end
        end
        prev_done = done;
    end

    // Call just after a negedge. Start is sampled at the next posedge (E0).
    task automatic issue(input longint a);
        exp_t e;
        real  r;
        start = 1'b1;
        angle = W'(a);
        @(posedge clk);
        #1;
        start = 1'b0;
        r     = real'(a) / (2.0 ** F);
        e.c   = to_q($cos(r));
        e.s   = to_q($sin(r));
        e.due = cyc + STAGES;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sb.size() != 0 && n < 4 * (STAGES + 1));
        if (sb.size() != 0) begin
            check(1'b0, {name, "_timeout"}, longint'(sb.size()), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint pi_q, hp_q, a, a1, a2;
        longint dir_tab [6];
        real    r;
        int     n;

        pi_q = to_q(PI_R);
        hp_q = to_q(PI_R / 2.0);

        // Reset state.
        #2 rst_n = 1'b0;
        #20;
        check(busy == 1'b0, "reset_busy", longint'(busy), 0);
        check(done == 1'b0, "reset_done", longint'(done), 0);
        check(cos_out == '0, "reset_cos", longint'(cos_out), 0);
        check(sin_out == '0, "reset_sin", longint'(sin_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero angle. busy must cover exactly STAGES cycles, then done follows.
        issue(0);
        for (int k = 0; k < STAGES; k++) begin
            @(negedge clk);
            check(busy == 1'b1, "busy_span", longint'(busy), 1);
        end
        @(negedge clk);
        check(busy == 1'b0, "busy_end", longint'(busy), 0);
        check(done == 1'b1, "done_at_latency", longint'(done), 1);
        wait_drain("zero");

        // Directed angles: first quadrant, folding cases and the boundaries.
        dir_tab[0] = to_q(PI_R / 6.0);
        dir_tab[1] = to_q(3.0 * PI_R / 4.0);
        dir_tab[2] = -pi_q;
        dir_tab[3] = pi_q;
        dir_tab[4] = hp_q;
        dir_tab[5] = -hp_q;
        foreach (dir_tab[i]) begin
            issue(dir_tab[i]);
            wait_drain("directed");
        end

        // A start two cycles into RUN is ignored. Only the first result may appear.
        a1 = to_q(0.4);
        a2 = to_q(-2.5);
        issue(a1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        angle = W'(a2);
        @(posedge clk);
        #1;
        start = 1'b0;
        check(busy == 1'b1, "busy_while_ignored", longint'(busy), 1);
        wait_drain("busy_protect");
        repeat (2 * (STAGES + 1)) @(negedge clk);

        // A start in the done cycle is accepted.
        issue(to_q(1.1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 4 * (STAGES + 1));
        check(done == 1'b1, "b2b_first_done", longint'(done), 1);
        issue(to_q(-0.7));
        wait_drain("b2b");

        // Reset during RUN cycle 2 clears everything without a clock edge.
        issue(to_q(2.0));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check(busy == 1'b0, "midrun_busy", longint'(busy), 0);
        check(done == 1'b0, "midrun_done", longint'(done), 0);
        check(cos_out == '0, "midrun_cos", longint'(cos_out), 0);
        check(sin_out == '0, "midrun_sin", longint'(sin_out), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * (STAGES + 1)) @(negedge clk);
        issue(to_q(-1.3));
        wait_drain("after_reset");

        // Random sweep. Outputs must also hold across the next start.
        for (int i = 0; i < 256; i++) begin
            r = (real'($urandom) / 4294967295.0 * 2.0 - 1.0) * PI_R;
            a = to_q(r);
            if (a > pi_q)  a = pi_q;
            if (a < -pi_q) a = -pi_q;
            issue(a);
            check(absl(longint'(cos_out) - last_exp.c) <= TOL, "hold_cos", longint'(cos_out), last_exp.c);
            wait_drain("sweep");
        end

        wait_drain("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
